// File: rtl/wb_sram_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of the SRAM slave port.
// Grant is held for the owner's whole cyc; a watchdog aborts stalled strobes with err.
module wb_sram_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [15:0] timer_q, timer_d;

  logic req0, req1, own1, own_cyc, stalled;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own1    = gnt_q[1];
  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign stalled = s_stb_o & ~s_ack_i & ~s_err_i;
  assign gnt_o   = gnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      timer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    timer_d = 16'd0;
    unique case (state_q)
      IDLE: begin
        // last_q names the previous owner, so on contention the other master wins
        if (req0 && req1) begin
          gnt_d   = last_q ? 2'b01 : 2'b10;
          state_d = BUSY;
        end else if (req0) begin
          gnt_d   = 2'b01;
          state_d = BUSY;
        end else if (req1) begin
          gnt_d   = 2'b10;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          last_d  = own1;
        end else if (stalled) begin
          if (timer_q == TMO_LAST) state_d = ABORT;
          else                     timer_d = timer_q + 16'd1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = own1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (state_q == BUSY) begin
      if (own1) begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
      end else begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
      end
    end else if (state_q == ABORT) begin
      m0_err_o = ~own1;
      m1_err_o = own1;
    end
  end

endmodule

// File: tb/tb_wb_sram_rr_arbiter.sv
// Directed bench for wb_sram_rr_arbiter: per-cycle vector table plus watchdog
// and reset-mid-burst sequences. Built with TIMEOUT=8.
module tb_wb_sram_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  gnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_sram_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(gnt)
  );

  typedef struct {
    bit          rst, c0, s0, c1, s1, ack, err;
    logic [31:0] sdat;
    logic [1:0]  egnt;  // expected gnt_o
    logic [1:0]  eown;  // slave side driven by: 0 none, 1 m0, 2 m1
    logic [1:0]  eack;  // [0]=m0_ack_o [1]=m1_ack_o
    logic [1:0]  eerr;  // [0]=m0_err_o [1]=m1_err_o
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, c0, s0, c1, s1, ack, err, input logic [31:0] sdat,
                     input logic [1:0] egnt, eown, eack, eerr);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
    v.sdat = sdat; v.egnt = egnt; v.eown = eown; v.eack = eack; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic at_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic check_row(input int i, input vec_t v);
    string t;
    logic [31:0] e_adr, e_dat;
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    t = $sformatf("row%0d", i);
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_dat = '0;
    if (v.eown == 2'd1) begin
      e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we; e_adr = m0_adr; e_sel = m0_sel; e_dat = m0_dat;
    end else if (v.eown == 2'd2) begin
      e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we; e_adr = m1_adr; e_sel = m1_sel; e_dat = m1_dat;
    end
    chk({t, " gnt"},    32'(gnt),     32'(v.egnt));
    chk({t, " s_cyc"},  32'(s_cyc),   32'(e_cyc));
    chk({t, " s_stb"},  32'(s_stb),   32'(e_stb));
    chk({t, " s_we"},   32'(s_we),    32'(e_we));
    chk({t, " s_adr"},  s_adr,        e_adr);
    chk({t, " s_sel"},  32'(s_sel),   32'(e_sel));
    chk({t, " s_dat"},  s_wdat,       e_dat);
    chk({t, " m0_ack"}, 32'(m0_ack),  32'(v.eack[0]));
    chk({t, " m1_ack"}, 32'(m1_ack),  32'(v.eack[1]));
    chk({t, " m0_err"}, 32'(m0_err),  32'(v.eerr[0]));
    chk({t, " m1_err"}, 32'(m1_err),  32'(v.eerr[1]));
    chk({t, " m0_dat"}, m0_rdat,      (v.eown == 2'd1) ? v.sdat : 32'h0);
    chk({t, " m1_dat"}, m1_rdat,      (v.eown == 2'd2) ? v.sdat : 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'h3; m0_dat = 32'h1111_1111;
    m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_adr = 32'h200; m1_sel = 4'hC; m1_dat = 32'h2222_2222;
    s_rdat = '0; s_ack = 0; s_err = 0;

    //   rst c0 s0 c1 s1 ack err sdat           gnt    own  ack    err
    // single m0 read, ack 5 cycles after the request
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 1, 0, 32'hDEAD_BEEF,  2'b01, 1, 2'b01, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    // contention after reset: m0 first, then alternating with an idle gap
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'h0000_0A01,  2'b01, 1, 2'b01, 2'b00);
    add(0, 0, 0, 1, 1, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'h0000_0B01,  2'b10, 2, 2'b10, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b10, 2, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'h0000_0A02,  2'b01, 1, 2'b01, 2'b00);
    add(0, 0, 0, 1, 1, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    // m1 burst of 4 beats with a 2-cycle stb gap, m0 waiting throughout
    add(0, 1, 1, 1, 1, 1, 0, 32'hCAFE_0001,  2'b10, 2, 2'b10, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'hCAFE_0002,  2'b10, 2, 2'b10, 2'b00);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,          2'b10, 2, 2'b00, 2'b00);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,          2'b10, 2, 2'b00, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'hCAFE_0003,  2'b10, 2, 2'b10, 2'b00);
    add(0, 1, 1, 1, 1, 1, 0, 32'hCAFE_0004,  2'b10, 2, 2'b10, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b10, 2, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 1, 1, 0, 0, 1, 0, 32'h0000_0A03,  2'b01, 1, 2'b01, 2'b00);
    // slave err on m1 passes through and keeps the grant; ack with cyc drop still delivered
    add(0, 0, 0, 1, 1, 0, 0, 32'h0,          2'b01, 1, 2'b00, 2'b00);
    add(0, 0, 0, 1, 1, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 1, 1, 0, 1, 32'h0000_0E01,  2'b10, 2, 2'b00, 2'b10);
    add(0, 0, 0, 1, 0, 0, 0, 32'h0,          2'b10, 2, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 1, 0, 32'hA5A5_A5A5,  2'b10, 2, 2'b10, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 2'b00, 2'b00);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      at_cycle();
      reset = vecs[i].rst;
      m0_cyc = vecs[i].c0; m0_stb = vecs[i].s0;
      m1_cyc = vecs[i].c1; m1_stb = vecs[i].s1;
      s_ack = vecs[i].ack; s_err = vecs[i].err; s_rdat = vecs[i].sdat;
      settle();
      check_row(i, vecs[i]);
    end

    // watchdog: m0 write never acked, m1 waiting
    at_cycle();
    reset = 0; s_ack = 0; s_err = 0; s_rdat = '0;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m1_cyc = 1; m1_stb = 1;
    settle();
    chk("wd idle gnt", 32'(gnt), 32'h0);
    at_cycle(); settle();
    chk("wd gnt m0", 32'(gnt), 32'h1);
    chk("wd stb rise", 32'(s_stb), 32'h1);
    chk("wd s_we", 32'(s_we), 32'h1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      at_cycle(); settle();
      if (m0_err) begin
        n = k;
        break;
      end
    end
    chk("wd err delay", 32'(n), 32'd8);
    chk("wd abort s_cyc", 32'(s_cyc), 32'h0);
    chk("wd abort s_stb", 32'(s_stb), 32'h0);
    chk("wd abort m0_ack", 32'(m0_ack), 32'h0);
    chk("wd abort m1_err", 32'(m1_err), 32'h0);
    at_cycle();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    settle();
    chk("wd err one cycle", 32'(m0_err), 32'h0);
    chk("wd post idle gnt", 32'(gnt), 32'h0);
    at_cycle(); settle();
    chk("wd m1 next gnt", 32'(gnt), 32'h2);
    chk("wd m1 s_cyc", 32'(s_cyc), 32'h1);
    chk("wd m1 s_adr", s_adr, 32'h200);
    at_cycle();
    m1_cyc = 0; m1_stb = 0;
    settle();

    // reset in the middle of an m0 burst
    at_cycle();
    m0_cyc = 1; m0_stb = 1;
    settle();
    at_cycle();
    s_ack = 1; s_rdat = 32'h0000_0B0A;
    settle();
    chk("rst beat1 ack", 32'(m0_ack), 32'h1);
    at_cycle();
    reset = 1; s_rdat = 32'h0000_0B0B;
    settle();
    chk("rst beat2 gnt", 32'(gnt), 32'h1);
    at_cycle();
    reset = 0; s_ack = 0; s_rdat = 32'h1234_5678;
    m1_cyc = 1; m1_stb = 1;
    settle();
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst s_cyc", 32'(s_cyc), 32'h0);
    chk("rst s_stb", 32'(s_stb), 32'h0);
    chk("rst s_adr", s_adr, 32'h0);
    chk("rst s_dat", s_wdat, 32'h0);
    chk("rst m0_dat", m0_rdat, 32'h0);
    chk("rst m1_dat", m1_rdat, 32'h0);
    at_cycle(); settle();
    chk("rst then m0 first", 32'(gnt), 32'h1);
    chk("rst m0 sees data", m0_rdat, 32'h1234_5678);
    chk("rst m1 no data", m1_rdat, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_rr_arbiter.md
Name: wb_sram_rr_arbiter

Overview:
- Two-master to one-slave Wishbone round-robin arbiter placed in front of the SRAM memory slave port.
- Lets the Ethernet RX and TX DMA engines share one SRAM port fairly instead of using fixed priority.
- Holds the grant for the whole bus cycle of the owning master (cyc high), including multi-strobe bursts.
- Includes a watchdog that aborts a stalled access with a Wishbone error.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- SEL_W, 4, byte-select width (DATA_W/8).
- TIMEOUT, 64, max cycles a strobe may wait for slave ack/err before abort (range 2..65535).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe and write enable
- m0_adr_i  in  ADDR_W  master 0 address
- m0_sel_i  in  SEL_W  master 0 byte select
- m0_dat_i  in  DATA_W  master 0 write data
- m0_dat_o  out  DATA_W  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and error
- m1_*  same set as m0_*  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SRAM slave
- s_adr_o  out  ADDR_W  to SRAM slave
- s_sel_o  out  SEL_W  to SRAM slave
- s_dat_o  out  DATA_W  to SRAM slave
- s_dat_i  in  DATA_W  from SRAM slave
- s_ack_i, s_err_i  in  1 each  from SRAM slave
- gnt_o  out  2  one-hot current grant; 00 when idle (debug/status)

Behaviour:
- Reset: state=IDLE, gnt_o=00, last=1 (master 0 wins first contention), timer=0.
  - Reset also forces all outputs low: s_cyc_o/s_stb_o/s_we_o=0, s_adr/sel/dat_o=0, m*_ack_o=0, m*_err_o=0, m*_dat_o=0.
- Request: req_n = mN_cyc_i & mN_stb_i.
- IDLE:
  - Neither request: stay IDLE.
  - One request: grant that master.
  - Both requesting: grant master != last.
  - The grant registers at the clock edge, so s_cyc_o first rises one cycle after the request (arbitration latency 1 cycle). Go to BUSY.
- BUSY (master g granted):
  - s_cyc/stb/we/adr/sel/dat_o follow master g's inputs combinationally.
  - mg_ack_o = s_ack_i, mg_err_o = s_err_i, mg_dat_o = s_dat_i.
  - The non-granted master sees ack=0, err=0, dat=0.
- Grant hold: the grant is held while mg_cyc_i=1, even with stb low between beats.
  - When mg_cyc_i=0 is sampled: next state IDLE, last<=g.
  - s_cyc_o follows mg_cyc_i combinationally, so the slave sees cyc drop immediately.
- Handover: the other master's pending request is granted on the edge after IDLE is entered.
  - Minimum gap of 1 idle cycle between two masters' cycles. No same-cycle handover.
- Watchdog:
  - timer increments each BUSY cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - timer clears on ack, on err, or when stb is low.
  - When timer reaches TIMEOUT-1 with no ack, state=ABORT.
- ABORT (1 cycle):
  - s_cyc_o=s_stb_o=0; mg_err_o=1 for exactly this cycle; mg_ack_o=0.
  - Then go to IDLE and set last<=g. The master must drop cyc after err.
  - If it re-requests, it re-arbitrates normally.
- Slave err passes through to the granted master unchanged and does not release the grant.
- Simultaneous events:
  - A request from the other master during BUSY is ignored until IDLE.
  - cyc drop and ack in the same cycle: the ack is still delivered that cycle, then release.
- Reset mid-cycle: on the reset edge all state clears, outputs drop, and any in-flight SRAM access is abandoned. A write may be partially applied. Masters must also be reset.
- Widths: all datapaths are straight muxes, with no width conversion. The timer is 16 bits; TIMEOUT is compared as unsigned.

Test Plan:
- Single master read: m0 cyc/stb, adr=0x100, slave acks 5 cycles later with 0xDEADBEEF -> s_cyc_o rises 1 cycle after request; m0_ack_o pulses once with m0_dat_o=0xDEADBEEF; gnt_o returns to 00 the cycle after m0 drops cyc.
- Contention fairness: m0 and m1 both request continuously, each cycle one beat -> grants alternate 01,10,01,10 starting with m0 after reset, with 1 idle cycle between each; m1 never sees ack during m0 grant.
- Burst hold: m1 holds cyc for 4 strobes (stb low 2 cycles between beats 2 and 3) while m0 requests -> gnt_o stays 10 for all 4 acks; m0 granted only after m1 cyc drops.
- Watchdog: TIMEOUT=8, slave never acks m0 write -> m0_err_o high exactly 1 cycle, 8 cycles after s_stb_o rose; s_cyc_o low in that cycle; m1 granted next if requesting.
- Slave error pass-through: slave asserts s_err_i on m1 read -> m1_err_o=1 that cycle, m1_ack_o=0, grant held until m1 drops cyc.
- Reset mid-burst: reset asserted during m0 grant beat 2 -> next cycle all outputs 0, gnt_o=00; after release a simultaneous m0/m1 request is granted to m0 first.
